// File: rtl/ifetch32.sv
// Instruction fetch for the single-cycle MIPS core: PC register, word-addressed IMEM,
// next-PC selection, and a RUN/LOAD/FAULT controller for in-system program loading.
module ifetch32 #(
    parameter int          IMEM_AW  = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Jr,
    input  logic               Zero,
    input  logic [31:0]        Read_data_1,
    input  logic [31:0]        Addr_result,
    input  logic               stall,
    input  logic               prog_mode,
    input  logic               prog_we,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [31:0]        prog_data,
    output logic [31:0]        Instruction,
    output logic [31:0]        pc,
    output logic [31:0]        branch_base_addr,
    output logic [31:0]        opcplus4,
    output logic               fault,
    output logic [31:0]        instr_count
);

    localparam int DEPTH = 1 << IMEM_AW;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;

    logic [31:0] imem [DEPTH];

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        take_branch;
    logic        next_illegal;

    // IMEM has no reset; only the loader writes it.
    always_ff @(posedge clock) begin
        if (state_q == ST_LOAD && prog_we) begin
            imem[prog_addr] <= prog_data;
        end
    end

    assign pc_plus4    = pc_q + 32'd4;
    assign take_branch = (Branch & Zero) | (nBranch & ~Zero);

    always_comb begin
        next_pc = pc_plus4;
        if (Jr) begin
            next_pc = Read_data_1;
        end else if (Jmp | Jal) begin
            next_pc = {pc_plus4[31:28], Instruction[25:0], 2'b00};
        end else if (take_branch) begin
            next_pc = Addr_result;
        end
    end

    // Misaligned, or beyond the last IMEM word (this also catches pc+4 wrap).
    assign next_illegal = (|next_pc[1:0]) | (|next_pc[31:IMEM_AW+2]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        if (reset) begin
            state_d = ST_RUN;
            pc_d    = RESET_PC;
            count_d = '0;
        end else if (prog_mode) begin
            state_d = ST_LOAD;
            pc_d    = RESET_PC;
            count_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                    count_d = '0;
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (next_illegal) begin
                            state_d = ST_FAULT;
                        end else begin
                            pc_d    = next_pc;
                            count_d = count_q + 32'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        count_q <= count_d;
    end

    assign Instruction      = (state_q == ST_RUN) ? imem[pc_q[IMEM_AW+1:2]] : 32'h0;
    assign pc               = pc_q;
    assign branch_base_addr = pc_plus4;
    assign opcplus4         = Jal ? pc_plus4 : 32'h0;
    assign fault            = (state_q == ST_FAULT);
    assign instr_count      = count_q;

endmodule

// File: tb/tb_ifetch32.sv
// Directed bench for ifetch32: expected per-cycle outputs go through a scoreboard queue
// and are compared against the DUT mid-cycle with immediate assertions.
module tb_ifetch32;

    logic        clock;
    logic        reset;
    logic        Branch, nBranch, Jmp, Jal, Jr, Zero;
    logic [31:0] Read_data_1, Addr_result;
    logic        stall, prog_mode, prog_we;
    logic [13:0] prog_addr;
    logic [31:0] prog_data;
    logic [31:0] Instruction, pc, branch_base_addr, opcplus4, instr_count;
    logic        fault;

    ifetch32 dut (
        .clock(clock), .reset(reset),
        .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr), .Zero(Zero),
        .Read_data_1(Read_data_1), .Addr_result(Addr_result),
        .stall(stall), .prog_mode(prog_mode), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .Instruction(Instruction), .pc(pc), .branch_base_addr(branch_base_addr),
        .opcplus4(opcplus4), .fault(fault), .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] cnt;
        logic [31:0] opc;
        logic        flt;
        bit          chk_ins;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    logic [31:0] ref_mem [64];
    int          ld_addr [9] = '{0, 1, 2, 3, 4, 5, 16, 17, 32};
    logic [31:0] ld_data [9] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003,
                                 32'h0C00_0020, 32'h5555_0005, 32'h4040_4040, 32'h4444_4444,
                                 32'h8080_8080};

    task automatic chk(input string tag, input string fld, input logic [31:0] got,
                       input logic [31:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s.%s got=%h expected=%h", tag, fld, got, want);
        end
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL scoreboard empty got=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk(e.tag, "pc", pc, e.pc);
        chk(e.tag, "bba", branch_base_addr, e.pc + 32'd4);
        chk(e.tag, "cnt", instr_count, e.cnt);
        chk(e.tag, "opc", opcplus4, e.opc);
        chk(e.tag, "fault", {31'h0, fault}, {31'h0, e.flt});
        if (e.chk_ins) chk(e.tag, "ins", Instruction, e.ins);
    endtask

    // Inputs for this cycle are already driven; push expectation, settle, compare, advance.
    task automatic obs(input string tag, input logic [31:0] epc, input logic [31:0] eins,
                       input logic [31:0] ecnt, input logic [31:0] eopc, input logic eflt,
                       input bit ci);
        exp_t e;
        e.tag = tag; e.pc = epc; e.ins = eins; e.cnt = ecnt;
        e.opc = eopc; e.flt = eflt; e.chk_ins = ci;
        sb.push_back(e);
        #4;
        check_front();
        @(posedge clock); #1;
    endtask

    task automatic clr();
        Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Zero = 0;
        Read_data_1 = '0; Addr_result = '0; stall = 0; prog_we = 0;
        prog_addr = '0; prog_data = '0;
    endtask

    initial begin
        clr();
        reset = 1; prog_mode = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        for (int i = 0; i < 9; i++) ref_mem[ld_addr[i]] = ld_data[i];
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 0;
        obs("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // enter LOAD and write the program
        prog_mode = 1;
        @(posedge clock); #1;
        for (int i = 0; i < 9; i++) begin
            prog_we = 1; prog_addr = ld_addr[i][13:0]; prog_data = ld_data[i];
            @(posedge clock); #1;
        end
        clr();
        obs("load", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        prog_mode = 0;
        obs("load_exit", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        // sequential fetch
        for (int i = 0; i < 4; i++) begin
            obs("seq", 32'(i * 4), ref_mem[i], 32'(i), 32'h0, 1'b0, 1'b1);
        end

        // jal at 0x10
        Jal = 1;
        obs("jal", 32'h10, ref_mem[4], 32'd4, 32'h14, 1'b0, 1'b1);
        clr();
        Branch = 1; Zero = 1; Addr_result = 32'h40;
        obs("jal_tgt", 32'h80, ref_mem[32], 32'd5, 32'h0, 1'b0, 1'b1);
        clr();
        Branch = 1; Zero = 0; Addr_result = 32'h40;
        obs("beq_taken", 32'h40, ref_mem[16], 32'd6, 32'h0, 1'b0, 1'b1);
        clr();
        nBranch = 1; Zero = 0; Addr_result = 32'h40;
        obs("beq_nt", 32'h44, ref_mem[17], 32'd7, 32'h0, 1'b0, 1'b1);
        clr();

        // stall with a jr pending
        stall = 1; Jr = 1; Read_data_1 = 32'h14;
        for (int i = 0; i < 3; i++) begin
            obs("stall", 32'h40, ref_mem[16], 32'd8, 32'h0, 1'b0, 1'b1);
        end
        stall = 0;
        obs("jr_go", 32'h40, ref_mem[16], 32'd8, 32'h0, 1'b0, 1'b1);
        clr();

        // misaligned jr -> FAULT
        Jr = 1; Read_data_1 = 32'h16;
        obs("jr_ok", 32'h14, ref_mem[5], 32'd9, 32'h0, 1'b0, 1'b1);
        clr();
        obs("fault", 32'h14, 32'h0, 32'd9, 32'h0, 1'b1, 1'b1);
        reset = 1;
        obs("fault_hold", 32'h14, 32'h0, 32'd9, 32'h0, 1'b1, 1'b1);
        reset = 0;
        obs("fault_rst", 32'h0, ref_mem[0], 32'd0, 32'h0, 1'b0, 1'b1);

        // out-of-range jr -> FAULT
        Jr = 1; Read_data_1 = 32'h0001_0000;
        obs("range_run", 32'h4, ref_mem[1], 32'd1, 32'h0, 1'b0, 1'b1);
        clr();
        prog_mode = 1;
        obs("range_flt", 32'h4, 32'h0, 32'd1, 32'h0, 1'b1, 1'b1);

        // reset and prog_mode together: reset wins, then LOAD
        reset = 1;
        obs("fault_load", 32'h0, 32'h0, 32'd0, 32'h0, 1'b0, 1'b1);
        reset = 0;
        obs("rst_wins", 32'h0, ref_mem[0], 32'd0, 32'h0, 1'b0, 1'b1);
        prog_mode = 0;
        obs("then_load", 32'h0, 32'h0, 32'd0, 32'h0, 1'b0, 1'b1);
        obs("rerun", 32'h0, ref_mem[0], 32'd0, 32'h0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
